// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: control bit positions, widths and
// the EX/MEM and MEM/WB pipeline register records.
package mips_pkg;

    localparam int MC_MEMWRITE = 1;
    localparam int MC_BOP      = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int DATA_W      = 32;
    localparam int REG_W       = 5;

    typedef struct packed {
        logic [1:0]        m_ctrl;
        logic [1:0]        wb_ctrl;
        logic              zero;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] data_write;
        logic [REG_W-1:0]  wb_reg;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  wb_reg;
    } memwb_t;

    // A memory access (store, or load that writes back) with a non-word address.
    function automatic logic is_misaligned(input exmem_t e);
        logic mem_access;
        mem_access = e.m_ctrl[MC_MEMWRITE] |
                     (e.wb_ctrl[WB_MEMTOREG] & e.wb_ctrl[WB_REGWRITE]);
        return mem_access & (e.alu_out[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous word RAM; a write returns the new data on the
// same edge (write-first). Contents are never reset.
module data_memory
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array write and registered read port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
        end else begin
            rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: EX/MEM register, data memory access, branch
// resolution and the MEM/WB register feeding the write-back bus.
module memory_access
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PC_W   = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        M_control,
    input  logic [1:0]        WB_control,
    input  logic              zero,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [DATA_W-1:0] data_write,
    input  logic [REG_W-1:0]  WB_register,
    input  logic [PC_W-1:0]   branch_target,
    output logic              PC_sel,
    output logic [PC_W-1:0]   jump_address,
    output logic [DATA_W-1:0] busw,
    output logic [REG_W-1:0]  rw,
    output logic              reg_write,
    output logic              misaligned
);

    exmem_t            exmem_d, exmem_q;
    logic [PC_W-1:0]   target_d, target_q;
    memwb_t            memwb_d, memwb_q;
    logic              rd_fresh_d, rd_fresh_q;
    logic [DATA_W-1:0] rd_hold_d, rd_hold_q;

    logic              advance_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [DATA_W-1:0] read_data_s;

    assign advance_s  = flush | ~stall;
    assign mem_we_s   = exmem_q.m_ctrl[MC_MEMWRITE] & ~stall & ~reset;
    assign mem_addr_s = exmem_q.alu_out[ADDR_W+1:2];

    data_memory #(
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clock (clock),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (exmem_q.data_write),
        .rdata (ram_rdata_s)
    );

    // The RAM output port re-reads on every edge, so while MEM/WB is held
    // the value seen before the stall is kept in rd_hold_q instead.
    assign read_data_s = rd_fresh_q ? ram_rdata_s : rd_hold_q;

    // EX/MEM next state: flush inserts a bubble, stall holds
    always_comb begin
        exmem_d  = exmem_q;
        target_d = target_q;
        if (flush) begin
            exmem_d  = '0;
            target_d = '0;
        end else if (!stall) begin
            exmem_d.m_ctrl     = M_control;
            exmem_d.wb_ctrl    = WB_control;
            exmem_d.zero       = zero;
            exmem_d.alu_out    = ALU_out;
            exmem_d.data_write = data_write;
            exmem_d.wb_reg     = WB_register;
            target_d           = branch_target;
        end else begin
            exmem_d  = exmem_q;
            target_d = target_q;
        end
    end

    // MEM/WB next state and read-data hold tracking
    always_comb begin
        memwb_d    = memwb_q;
        rd_fresh_d = advance_s;
        rd_hold_d  = read_data_s;
        if (advance_s) begin
            memwb_d.reg_write  = exmem_q.wb_ctrl[WB_REGWRITE];
            memwb_d.mem_to_reg = exmem_q.wb_ctrl[WB_MEMTOREG];
            memwb_d.alu_out    = exmem_q.alu_out;
            memwb_d.wb_reg     = exmem_q.wb_reg;
        end else begin
            memwb_d = memwb_q;
        end
    end

    // Pipeline register state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exmem_q    <= '0;
            target_q   <= '0;
            memwb_q    <= '0;
            rd_fresh_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            exmem_q    <= exmem_d;
            target_q   <= target_d;
            memwb_q    <= memwb_d;
            rd_fresh_q <= rd_fresh_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    assign PC_sel       = exmem_q.m_ctrl[MC_BOP] & exmem_q.zero & ~stall;
    assign jump_address = target_q;
    assign misaligned   = is_misaligned(exmem_q);
    assign busw         = memwb_q.mem_to_reg ? read_data_s : memwb_q.alu_out;
    assign rw           = memwb_q.wb_reg;
    assign reg_write    = memwb_q.reg_write;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage; write-back results are checked by a
// scoreboard monitor, branch/misalign/reset behaviour by direct checks.
module tb_memory_access;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset, stall, flush, zero;
    logic [1:0]  M_control, WB_control;
    logic [31:0] ALU_out, data_write, busw;
    logic [4:0]  WB_register, rw;
    logic [9:0]  branch_target, jump_address;
    logic        PC_sel, reg_write, misaligned;

    typedef struct packed {
        logic [31:0] busw;
        logic [4:0]  rw;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    memory_access #(.ADDR_W(8), .PC_W(10)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .M_control(M_control), .WB_control(WB_control), .zero(zero),
        .ALU_out(ALU_out), .data_write(data_write), .WB_register(WB_register),
        .branch_target(branch_target), .PC_sel(PC_sel),
        .jump_address(jump_address), .busw(busw), .rw(rw),
        .reg_write(reg_write), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 1'b0; flush = 1'b0; M_control = 2'b00; WB_control = 2'b00;
        zero = 1'b0; ALU_out = 32'h0; data_write = 32'h0;
        WB_register = 5'd0; branch_target = 10'h0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [1:0] wb, input logic z,
                         input logic [31:0] alu, input logic [31:0] dw,
                         input logic [4:0] r, input logic [9:0] bt,
                         input logic fl, input logic [31:0] exp_busw);
        M_control = m; WB_control = wb; zero = z; ALU_out = alu;
        data_write = dw; WB_register = r; branch_target = bt;
        flush = fl; stall = 1'b0;
        if (!fl && wb[1]) exp_q.push_back('{busw: exp_busw, rw: r});
        @(posedge clock); #1;
        drive_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc_sel"},    32'(PC_sel),       32'h0);
        chk({tag, "_jump"},      32'(jump_address), 32'h0);
        chk({tag, "_busw"},      busw,              32'h0);
        chk({tag, "_rw"},        32'(rw),           32'h0);
        chk({tag, "_reg_write"}, 32'(reg_write),    32'h0);
        chk({tag, "_misalign"},  32'(misaligned),   32'h0);
    endtask

    // Scoreboard monitor: one write-back per edge at which MEM/WB advanced
    initial begin
        logic    adv;
        wb_exp_t e;
        forever begin
            @(posedge clock);
            adv = (flush | ~stall) & ~reset;
            @(negedge clock);
            if (adv && !reset && reg_write) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: got busw=%h rw=%0d expected none", busw, rw);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_busw", busw, e.busw);
                    chk("wb_rw", 32'(rw), 32'(e.rw));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset_init");
        @(negedge clock);
        reset = 1'b0;

        // Seed word 0 for the discarded-store check at the end
        issue(2'b10, 2'b00, 1'b0, 32'h0, 32'h0000AAAA, 5'd0, 10'h0, 1'b0, 32'h0);
        // R-type pass-through
        issue(2'b00, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd3, 10'h0, 1'b0, 32'h1234);
        // Store then back-to-back load of the same word
        issue(2'b10, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 10'h0, 1'b0, 32'h0);
        issue(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 5'd7, 10'h0, 1'b0, 32'hDEADBEEF);

        // Branch taken / not taken
        issue(2'b01, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h05A, 1'b0, 32'h0);
        chk("br_taken_pc_sel", 32'(PC_sel), 32'h1);
        chk("br_taken_jump", 32'(jump_address), 32'h05A);
        issue(2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h123, 1'b0, 32'h0);
        chk("br_not_taken_pc_sel", 32'(PC_sel), 32'h0);
        chk("br_not_taken_jump", 32'(jump_address), 32'h123);

        // Address wrap: 0x404 aliases word 1
        issue(2'b10, 2'b00, 1'b0, 32'h4, 32'h11112222, 5'd0, 10'h0, 1'b0, 32'h0);
        chk("aligned_store_misalign", 32'(misaligned), 32'h0);
        issue(2'b00, 2'b11, 1'b0, 32'h404, 32'h0, 5'd8, 10'h0, 1'b0, 32'h11112222);

        // Misaligned store lands in word 4; misaligned load also flagged
        issue(2'b10, 2'b00, 1'b0, 32'h11, 32'hCAFEF00D, 5'd0, 10'h0, 1'b0, 32'h0);
        chk("misaligned_store", 32'(misaligned), 32'h1);
        issue(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 5'd9, 10'h0, 1'b0, 32'hCAFEF00D);
        issue(2'b00, 2'b11, 1'b0, 32'h12, 32'h0, 5'd16, 10'h0, 1'b0, 32'hCAFEF00D);
        chk("misaligned_load", 32'(misaligned), 32'h1);

        // Flushed store and flushed R-type leave no trace
        issue(2'b10, 2'b00, 1'b0, 32'h11, 32'hBAD0BAD0, 5'd0, 10'h0, 1'b1, 32'h0);
        chk("flush_store_misalign", 32'(misaligned), 32'h0);
        issue(2'b00, 2'b10, 1'b0, 32'h55, 32'h0, 5'd11, 10'h0, 1'b1, 32'h0);
        issue(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h0, 1'b0, 32'h0);
        chk("flush_reg_write", 32'(reg_write), 32'h0);
        issue(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 5'd10, 10'h0, 1'b0, 32'hCAFEF00D);

        // Stall for three edges with a store in MEM and an R-type in WB
        issue(2'b00, 2'b10, 1'b0, 32'h77, 32'h0, 5'd12, 10'h0, 1'b0, 32'h77);
        issue(2'b10, 2'b00, 1'b0, 32'h21, 32'h5A5A5A5A, 5'd0, 10'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            @(posedge clock); #1;
            chk("stall_busw", busw, 32'h77);
            chk("stall_rw", 32'(rw), 32'd12);
            chk("stall_reg_write", 32'(reg_write), 32'h1);
            chk("stall_exmem_hold", 32'(misaligned), 32'h1);
        end
        stall = 1'b0;
        issue(2'b00, 2'b11, 1'b0, 32'h20, 32'h0, 5'd13, 10'h0, 1'b0, 32'h5A5A5A5A);

        // PC_sel is suppressed while stalled, then returns
        issue(2'b01, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h3FF, 1'b0, 32'h0);
        chk("br_pre_stall_pc_sel", 32'(PC_sel), 32'h1);
        stall = 1'b1;
        #1;
        chk("br_stall_pc_sel", 32'(PC_sel), 32'h0);
        @(posedge clock); #1;
        stall = 1'b0;
        #1;
        chk("br_post_stall_pc_sel", 32'(PC_sel), 32'h1);
        chk("br_post_stall_jump", 32'(jump_address), 32'h3FF);

        // rw=0 with reg_write=1 passes through
        issue(2'b00, 2'b10, 1'b0, 32'hABC, 32'h0, 5'd0, 10'h0, 1'b0, 32'hABC);

        // Asynchronous reset in the middle of a cycle
        issue(2'b00, 2'b10, 1'b0, 32'h99, 32'h0, 5'd14, 10'h0, 1'b0, 32'h99);
        issue(2'b11, 2'b00, 1'b1, 32'h3, 32'hFFFFFFFF, 5'd0, 10'h2AA, 1'b0, 32'h0);
        chk("pre_reset_pc_sel", 32'(PC_sel), 32'h1);
        chk("pre_reset_misalign", 32'(misaligned), 32'h1);
        chk("pre_reset_reg_write", 32'(reg_write), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;

        // Word 0 still holds its seed: the in-flight store was dropped
        issue(2'b00, 2'b11, 1'b0, 32'h0, 32'h0, 5'd15, 10'h0, 1'b0, 32'h0000AAAA);
        repeat (3) issue(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h0, 1'b0, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the MIPS/DLX pipeline, directly downstream of `execution`.
- Contains the EX/MEM pipeline register, a synchronous word-addressed data memory and the MEM/WB pipeline register.
- Resolves conditional branches and returns `PC_sel`/`jump_address` to `instruction_fetch`.
- Drives the write-back bus (`busw`, `rw`, `reg_write`) consumed by `instruction_decode`.

Parameters:
- ADDR_W, 8, data memory word-address width; DEPTH = 2**ADDR_W words of 32 bits.
- PC_W, 10, width of the branch target/PC field; matches the fetch stage PC width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold both pipeline registers; suppress memory write.
- flush  in  1  insert a bubble into EX/MEM on the next edge.
- M_control  in  2  [1]=MemWrite, [0]=BOP (branch operation), from decode via EX.
- WB_control  in  2  [1]=RegWrite, [0]=MemToReg.
- zero  in  1  ALU zero flag from `execution`.
- ALU_out  in  32  ALU result; byte address for loads/stores.
- data_write  in  32  store data from `execution`.
- WB_register  in  5  destination register from `execution`.
- branch_target  in  PC_W  branch target computed upstream.
- PC_sel  out  1  branch taken; selects `jump_address` in fetch.
- jump_address  out  PC_W  registered branch target.
- busw  out  32  write-back data.
- rw  out  5  write-back register number.
- reg_write  out  1  write-back enable.
- misaligned  out  1  the access in MEM has ALU_out[1:0] != 0 with MemWrite set, or MemToReg with RegWrite set.

Behaviour:
- Reset (async, immediate): EX/MEM and MEM/WB registers clear to 0. Outputs `PC_sel`=0, `jump_address`=0, `busw`=0, `rw`=0, `reg_write`=0, `misaligned`=0. Memory contents are not reset.
- EX/MEM register latches M_control, WB_control, zero, ALU_out, data_write, WB_register and branch_target each edge when stall=0.
- Priority at an edge: reset > flush > stall > normal.
  - flush=1: EX/MEM controls (M, WB) load 0; data fields are don't-care and load 0. MEM/WB still advances.
  - stall=1 and flush=0: both registers hold; no memory write occurs.
- Memory address is exmem_ALU_out[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words. Bits [1:0] are ignored for the access and reported only via `misaligned`.
- Write: at the rising edge ending the MEM cycle, if exmem MemWrite=1 and stall=0, mem[addr] <= exmem_data_write. Misaligned stores are still performed at the truncated address.
- Read: synchronous, latched into MEM/WB at the same edge. Read-during-write to the same address returns the new data (write-first).
- `PC_sel` = exmem_BOP & exmem_zero, combinational from the EX/MEM register. It is valid during the MEM cycle and forced 0 while stall=1.
- `jump_address` = exmem_branch_target.
- MEM/WB register latches read data, ALU_out, WB_register, RegWrite and MemToReg.
- `busw` = MemToReg ? memwb_read_data : memwb_alu_out. `rw` = memwb_WB_register. `reg_write` = memwb_RegWrite.
- Latency:
  - Inputs sampled at edge N.
  - Branch decision visible in cycle N..N+1.
  - Write-back outputs valid after edge N+1, i.e. two edges from EX output to `busw`.
- Store followed by a load to the same address on consecutive instructions: the load returns the stored value with no stall. This holds because the store writes at edge N+1 and the load reads at edge N+2.
- rw=0 with reg_write=1 is passed through unchanged; register 0 suppression belongs to decode.
- Reset asserted mid-operation: the in-flight store is discarded if reset is high at its edge, and pipeline contents are lost.

Decomposition:
- Package `mips_pkg`:
  - Bit indices MC_MEMWRITE=1, MC_BOP=0, WB_REGWRITE=1, WB_MEMTOREG=0.
  - Widths DATA_W=32, REG_W=5.
  - EX/MEM and MEM/WB record typedefs.
- Sub-module `data_memory`:
  - Single-port, synchronous write-first RAM.
  - Parameter ADDR_W.
  - Ports clock, we, addr, wdata, rdata.
  - No reset.

Test Plan:
- Reset: assert reset mid-cycle with prior traffic -> all outputs 0 immediately, with no clock edge required.
- Store then load: SW with ALU_out=0x10, data_write=0xDEADBEEF, M=2'b10, WB=0; next LW with ALU_out=0x10, WB=2'b11, WB_register=7 -> two edges later busw=0xDEADBEEF, rw=7, reg_write=1.
- R-type pass-through: ALU_out=0x1234, WB=2'b10, WB_register=3 -> busw=0x1234, rw=3 after two edges; memory unchanged.
- Branch: M=2'b01, zero=1, branch_target=10'h05A -> PC_sel=1, jump_address=0x05A in the cycle after sampling. Same with zero=0 -> PC_sel=0.
- Stall/flush: store sampled, then stall=1 for 3 cycles -> no write and outputs held; release -> write occurs once. Flush on a store -> memory unchanged and reg_write=0.
- Wrap/misalign: ALU_out=0x404 with ADDR_W=8 aliases to word 1. ALU_out=0x11 store -> misaligned=1 during MEM and data written to word 4.
